mu_seq_mult: RTL and testbench

Iterative signed multiplier: the parametrised, sequential successor to the combinational Baugh-Wooley array cells. It accumulates one partial-product row per clock, using AND cells for ordinary bits and NAND cells for sign-position bits. A start/busy/done handshake makes it usable as a multi-cycle functional unit in the CPU datapath. Area is one row of cells plus a 2·WIDTH accumulator, instead of WIDTH² cells.

---
 rtl/mu_seq_mult.sv | 73 +++++++
 tb/tb_mu_seq_mult.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu_seq_mult.sv
// mu_seq_mult: iterative Baugh-Wooley signed multiplier, one partial-product row per clock.
// Define MU_UNSIGNED_MODE_EN to add the is_signed port for unsigned operation.
module mu_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef MU_UNSIGNED_MODE_EN
  input  logic                 is_signed,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [2*WIDTH-1:0] ONE = 1;
  localparam logic [2*WIDTH-1:0] BW_K = (ONE << WIDTH) | (ONE << (2*WIDTH-1));
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] x, y, row;
  logic [2*WIDTH-1:0] acc, nxt;
  logic [IW-1:0] i;
  logic sg, sg_in, last;
`ifdef MU_UNSIGNED_MODE_EN
  assign sg_in = is_signed;
`else
  assign sg_in = 1'b1;
`endif
  // Sign-position cells become NAND: the MSB on ordinary rows, every other bit on the last row.
  always_comb begin
    last = i == IW'(WIDTH-1);
    row = (x & {WIDTH{y[i]}}) ^ (sg ? (last ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}}) : '0);
    nxt = acc + ({{WIDTH{1'b0}}, row} << i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      product <= '0;
      acc <= '0;
      i <= '0;
      x <= '0;
      y <= '0;
      sg <= 1'b0;
    end else if (state != CALC) begin
      done <= 1'b0;
      if (start) begin
        x <= a;
        y <= b;
        sg <= sg_in;
        i <= '0;
        acc <= sg_in ? BW_K : '0;
        busy <= 1'b1;
        state <= CALC;
      end else begin
        state <= IDLE;
      end
    end else begin
      acc <= nxt;
      i <= i + 1'b1;
      if (last) begin
        product <= nxt;
        done <= 1'b1;
        busy <= 1'b0;
        state <= DONE;
      end
    end
  end
endmodule

// File: tb/tb_mu_seq_mult.sv
// tb_mu_seq_mult: directed self-checking bench for mu_seq_mult at WIDTH=8.
module tb_mu_seq_mult;
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [7:0] a, b;
  logic is_signed;
  logic busy, done;
  logic [15:0] product;
  int checks = 0;
  int errors = 0;

  mu_seq_mult #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
`ifdef MU_UNSIGNED_MODE_EN
    .is_signed(is_signed),
`endif
    .busy(busy),
    .done(done),
    .product(product)
  );

  always #5 clk = ~clk;

  // Pulses start for one accepting edge and counts edges until done (lat=-1 on timeout).
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, output logic [15:0] p, output int lat);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    p = product;
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    is_signed = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b product=%h want 0 0 0000", busy, done, product);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_min_operands;
    logic [15:0] p;
    int lat;
    @(negedge clk);
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept: got %b want 1", busy);
    end
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    p = product;
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL latency: got %0d want 8", lat);
    end
    checks++;
    if (p !== 16'h4000) begin
      errors++;
      $display("FAIL min_x_min: got %h want 4000", p);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_done: got %b want 0", busy);
    end
    @(posedge clk);
    #1 checks++;
    if (done !== 1'b0 || product !== 16'h4000) begin
      errors++;
      $display("FAIL done_pulse: done=%b product=%h want 0 4000", done, product);
    end
  endtask

  task automatic test_basic;
    logic [15:0] p;
    int lat;
    run_op(8'h7F, 8'hFF, p, lat);
    checks++;
    if (p !== 16'hFF81 || lat !== 8) begin
      errors++;
      $display("FAIL 127x-1: got %h lat %0d want ff81 lat 8", p, lat);
    end
    run_op(8'h00, 8'h5A, p, lat);
    checks++;
    if (p !== 16'h0000 || lat !== 8) begin
      errors++;
      $display("FAIL 0x90: got %h lat %0d want 0000 lat 8", p, lat);
    end
    run_op(8'h7F, 8'h7F, p, lat);
    checks++;
    if (p !== 16'h3F01) begin
      errors++;
      $display("FAIL 127x127: got %h want 3f01", p);
    end
    run_op(8'h80, 8'h7F, p, lat);
    checks++;
    if (p !== 16'hC080) begin
      errors++;
      $display("FAIL -128x127: got %h want c080", p);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int first;
    first = -1;
    @(negedge clk);
    a = 8'h03;
    b = 8'hFB;
    start = 1'b1;
    @(posedge clk);
    #1 a = 8'hF9;
    b = 8'h07;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1 lat++;
      if (done && first < 0) begin
        first = lat;
        checks++;
        if (product !== 16'hFFF1) begin
          errors++;
          $display("FAIL b2b_first: got %h want fff1", product);
        end
      end else if (done) begin
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (first !== 8 || lat !== 17) begin
      errors++;
      $display("FAIL b2b_spacing: done at %0d and %0d want 8 and 17", first, lat);
    end
    checks++;
    if (product !== 16'hFFCF) begin
      errors++;
      $display("FAIL b2b_second: got %h want ffcf", product);
    end
    @(posedge clk);
    #1 checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    a = 8'h10;
    b = 8'h0C;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk);
      #1 lat++;
      start = (lat == 3);
      if (lat == 3) begin
        a = 8'h7F;
        b = 8'h7F;
      end
    end
    start = 1'b0;
    checks++;
    if (lat !== 8 || product !== 16'h00C0) begin
      errors++;
      $display("FAIL ignore_start: product %h lat %0d want 00c0 lat 8", product, lat);
    end
    @(posedge clk);
    #1 checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy_ext: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_async_reset;
    logic [15:0] p;
    int lat;
    logic seen;
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b product=%h want 0 0 0000", busy, done, product);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | done;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL no_done_after_reset: got done=1 want none");
    end
    run_op(8'h02, 8'h03, p, lat);
    checks++;
    if (p !== 16'h0006 || lat !== 8) begin
      errors++;
      $display("FAIL after_reset: got %h lat %0d want 0006 lat 8", p, lat);
    end
  endtask

  task automatic test_unsigned;
    logic [15:0] p;
    int lat;
`ifdef MU_UNSIGNED_MODE_EN
    is_signed = 1'b0;
    run_op(8'hFF, 8'hFF, p, lat);
    checks++;
    if (p !== 16'hFE01 || lat !== 8) begin
      errors++;
      $display("FAIL unsigned_ff: got %h lat %0d want fe01 lat 8", p, lat);
    end
    is_signed = 1'b1;
`endif
    run_op(8'hFF, 8'hFF, p, lat);
    checks++;
    if (p !== 16'h0001) begin
      errors++;
      $display("FAIL signed_ff: got %h want 0001", p);
    end
  endtask

  initial begin
    test_reset();
    test_min_operands();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
    test_unsigned();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
